seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for the PDU's N-digit 7-segment display.

---
 rtl/seg_scan_if.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Bus bundle between the PDU display logic and the 7-segment scan controller.
// The master drives content and timing, the slave drives the active-low display pins.
interface seg_scan_if #(
  parameter int N_DIG = 8
);
  logic                 tick;
  logic                 load;
  logic [4*N_DIG-1:0]   data;
  logic [N_DIG-1:0]     dig_en;
  logic [N_DIG-1:0]     dp;
  logic                 blank_lz;
  logic [N_DIG-1:0]     an;
  logic [6:0]           seg;
  logic                 dp_n;
  logic                 frame_done;
  logic                 load_ack;

  modport master (
    output tick, load, data, dig_en, dp, blank_lz,
    input  an, seg, dp_n, frame_done, load_ack
  );

  modport slave (
    input  tick, load, data, dig_en, dp, blank_lz,
    output an, seg, dp_n, frame_done, load_ack
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with anode dead-time and
// frame-aligned double buffering of the display contents.
module seg_scan_ctrl #(
  parameter int N_DIG     = 8,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int DCNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int DW     = 4 * N_DIG;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_DIG - 1);
  localparam logic [DCNT_W-1:0] DCNT_INI = DCNT_W'(BLANK_CYC);
  localparam logic [N_DIG-1:0]  ONE_HOT0 = {{(N_DIG-1){1'b0}}, 1'b1};

  typedef enum logic {SHOW, DEAD} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
  logic                wrap;

  logic                pending;
  logic [DW-1:0]       stg_data, sh_data;
  logic [N_DIG-1:0]    stg_en, sh_en, stg_dp, sh_dp;

  logic [3:0]          nib;
  logic                lit;
  logic [N_DIG-1:0]    an_nxt, an_q;
  logic [6:0]          seg_nxt, seg_q;
  logic                dpn_nxt, dpn_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  function automatic logic lz_blank(input logic [DW-1:0] d, input logic [IDX_W-1:0] i,
                                    input logic en);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < N_DIG; j++) begin
      if (j >= int'(i) && d[4*j +: 4] != 4'h0) nz = 1'b1;
    end
    return en && (i != '0) && !nz;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dcnt_nxt  = dcnt;
    wrap      = 1'b0;
    case (state)
      SHOW: begin
        if (bus.tick) begin
          wrap    = (idx == LAST_IDX);
          idx_nxt = wrap ? '0 : idx + 1'b1;
          if (BLANK_CYC != 0) begin
            state_nxt = DEAD;
            dcnt_nxt  = DCNT_INI;
          end
        end
      end
      DEAD: begin
        dcnt_nxt = dcnt - 1'b1;
        if (dcnt <= DCNT_W'(1)) state_nxt = SHOW;
      end
      default: state_nxt = SHOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SHOW;
      idx   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Staging accepts every load; shadow only changes on the frame wrap, and a
  // load landing exactly on the wrap bypasses staging so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      stg_data <= '0;
      stg_en   <= '0;
      stg_dp   <= '0;
      sh_data  <= '0;
      sh_en    <= '0;
      sh_dp    <= '0;
    end else begin
      if (bus.load) begin
        stg_data <= bus.data;
        stg_en   <= bus.dig_en;
        stg_dp   <= bus.dp;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (bus.load) begin
          sh_data <= bus.data;
          sh_en   <= bus.dig_en;
          sh_dp   <= bus.dp;
        end else if (pending) begin
          sh_data <= stg_data;
          sh_en   <= stg_en;
          sh_dp   <= stg_dp;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    nib     = sh_data[{idx, 2'b00} +: 4];
    lit     = (state == SHOW) && sh_en[idx] && !lz_blank(sh_data, idx, bus.blank_lz);
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dpn_nxt = 1'b1;
    if (lit) begin
      an_nxt  = ~(ONE_HOT0 << idx);
      seg_nxt = hex7(nib);
      dpn_nxt = ~sh_dp[idx];
    end
  end

  // Output register stage: pins follow state/idx one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 7'h7F;
      dpn_q <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dpn_q <= dpn_nxt;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dpn_q;
  assign bus.frame_done = wrap;
  assign bus.load_ack   = wrap & (pending | bus.load);

endmodule
